// File: rtl/fo_loop_filter.sv
// fo_loop_filter
//   Frequency-offset loop filter: first-order IIR smoothing of upstream
//   frequency-offset estimates, an NCO phase accumulator driven by the
//   filtered offset, and a lock detector on the filter error.
//
// Ports
//   clk             : single clock, rising edge
//   rst_sync        : synchronous active-high reset
//   i_enable        : block enable; 0 returns the block to IDLE and clears it
//   i_fo_valid      : new estimate strobe
//   i_fo_value      : signed 15-bit estimate
//   i_valid         : data-block strobe, advances the NCO
//   i_hold          : freezes the loop filter (NCO keeps running)
//   i_alpha_shift   : IIR gain shift, clamped to 12
//   i_lock_thr      : unsigned lock threshold in estimate LSBs
//   o_fo_filt       : signed filtered offset (acc[22:8])
//   o_fo_filt_valid : pulse one cycle after each accepted estimate
//   o_phase         : NCO phase, modulo 2^16
//   o_phase_valid   : pulse one cycle after each NCO advance
//   o_locked        : lock indicator
//   o_sat           : sticky accumulator-saturation flag
module fo_loop_filter (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        i_enable,
    input  logic        i_fo_valid,
    input  logic [14:0] i_fo_value,
    input  logic        i_valid,
    input  logic        i_hold,
    input  logic [3:0]  i_alpha_shift,
    input  logic [13:0] i_lock_thr,
    output logic [14:0] o_fo_filt,
    output logic        o_fo_filt_valid,
    output logic [15:0] o_phase,
    output logic        o_phase_valid,
    output logic        o_locked,
    output logic        o_sat
);

    typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_TRACK, S_HOLD} state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic signed [22:0] r_acc;
    logic [15:0]        r_phase;
    logic [2:0]         r_lock_cnt;
    logic               r_locked;
    logic               r_sat;
    logic               r_filt_vld;
    logic               r_phase_vld;

    // strobes decoded from the state
    logic               w_clear;
    logic               w_load;
    logic               w_update;
    logic               w_nco_adv;

    // datapath
    logic signed [22:0] w_est;
    logic signed [23:0] w_err;
    logic [3:0]         w_shift;
    logic signed [23:0] w_err_sh;
    logic signed [24:0] w_sum;
    logic signed [22:0] w_acc_next;
    logic               w_ovf;
    logic signed [15:0] w_err_q;
    logic [15:0]        w_mag16;
    logic [13:0]        w_mag;
    logic               w_qual;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst_sync) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (!i_enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_state_next = S_ACQUIRE;
                S_ACQUIRE: if (i_fo_valid) w_state_next = S_TRACK;
                S_TRACK:   if (i_hold)     w_state_next = S_HOLD;
                S_HOLD:    if (!i_hold)    w_state_next = S_TRACK;
                default:   w_state_next = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs (datapath strobes) ----------------
    // Dropping i_enable wins over everything: the block is heading to IDLE,
    // which clears all state, so no update or pulse is issued that cycle.
    // A TRACK cycle with i_hold already asserted is treated as frozen.
    always_comb begin
        w_clear   = !i_enable;
        w_load    = 1'b0;
        w_update  = 1'b0;
        w_nco_adv = 1'b0;
        if (i_enable) begin
            w_load    = (r_state == S_ACQUIRE) && i_fo_valid;
            w_update  = (r_state == S_TRACK) && !i_hold && i_fo_valid;
            w_nco_adv = ((r_state == S_TRACK) || (r_state == S_HOLD)) && i_valid;
        end
    end

    // ---------------- IIR datapath ----------------
    always_comb begin
        w_est    = {i_fo_value, 8'd0};
        w_err    = {w_est[22], w_est} - {r_acc[22], r_acc};
        w_shift  = (i_alpha_shift > 4'd12) ? 4'd12 : i_alpha_shift;
        w_err_sh = w_err >>> w_shift;
        w_sum    = {w_err_sh[23], w_err_sh} + {{2{r_acc[22]}}, r_acc};

        // Clamp to the 23-bit range. With a 15-bit estimate the update is a
        // convex step between acc and the estimate, so this is a guard.
        w_ovf      = (w_sum[24:22] != 3'b000) && (w_sum[24:22] != 3'b111);
        w_acc_next = w_sum[22:0];
        if (w_ovf) w_acc_next = w_sum[24] ? 23'sh400000 : 23'sh3FFFFF;

        // |e>>>8|, computed unsigned so -32768 maps to 32768, then clamped
        w_err_q = w_err[23:8];
        w_mag16 = w_err_q[15] ? (~w_err_q + 16'd1) : w_err_q;
        w_mag   = (w_mag16 > 16'd16383) ? 14'h3FFF : w_mag16[13:0];
        w_qual  = (w_mag <= i_lock_thr);
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst_sync || w_clear) begin
            r_acc       <= '0;
            r_phase     <= '0;
            r_lock_cnt  <= '0;
            r_locked    <= 1'b0;
            r_sat       <= 1'b0;
            r_filt_vld  <= 1'b0;
            r_phase_vld <= 1'b0;
        end else begin
            r_filt_vld  <= w_load || w_update;
            r_phase_vld <= w_nco_adv;

            // NCO uses the current (pre-update) filtered value
            if (w_nco_adv)
                r_phase <= r_phase + {r_acc[22], r_acc[22:8]};

            if (w_load) begin
                r_acc <= w_est;
            end else if (w_update) begin
                r_acc <= w_acc_next;
                if (w_ovf) r_sat <= 1'b1;
                // counter holds 7 after seven hits; the eighth sets lock
                if (w_qual) begin
                    if (r_lock_cnt == 3'd7) r_locked   <= 1'b1;
                    else                    r_lock_cnt <= r_lock_cnt + 3'd1;
                end else begin
                    r_lock_cnt <= '0;
                    r_locked   <= 1'b0;
                end
            end
        end
    end

    assign o_fo_filt       = r_acc[22:8];
    assign o_fo_filt_valid = r_filt_vld;
    assign o_phase         = r_phase;
    assign o_phase_valid   = r_phase_vld;
    assign o_locked        = r_locked;
    assign o_sat           = r_sat;

endmodule
